// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a programmable hold limit.
// The grant index, the one-hot grant and the preempt pulse are all registered.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,  // max consecutive grant cycles per tenure; 0 means unlimited
  parameter int CNT_W    = 4   // hold-counter width; MAX_HOLD <= 2**CNT_W - 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } search_t;

  localparam bit               LIMIT_EN  = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Scan last+1, last+2, last+3, last (mod 4); the first active request wins.
  // Walking the offsets from farthest to nearest lets the nearest hit overwrite the others.
  function automatic search_t search(input logic [3:0] r, input logic [1:0] l);
    search_t    s;
    logic [1:0] k;
    s = '0;
    for (int n = 4; n >= 1; n--) begin
      k = l + 2'(n);
      if (r[k]) begin
        s.found = 1'b1;
        s.idx   = k;
      end
    end
    return s;
  endfunction

  // 2-to-4 decoder stage: line k is the grant for requester k, gated by the enable.
  function automatic logic [3:0] dec2to4(input logic [1:0] idx, input logic en);
    logic [3:0] d;
    d = 4'b0001 << idx;
    return en ? d : 4'b0000;
  endfunction

  state_t           state, state_nxt;
  logic [1:0]       idx_nxt;
  logic             valid_nxt;
  logic             preempt_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [1:0]       last, last_nxt;
  search_t          hit;
  logic             keep;
  logic             timeout;

  // State register: every output and the round-robin pointer update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      gnt       <= 4'b0000;
      preempt   <= 1'b0;
      hold_cnt  <= '0;
      last      <= 2'd3;  // first search after reset starts at requester 0
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state     <= state_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      gnt       <= dec2to4(idx_nxt, valid_nxt);
      preempt   <= preempt_nxt;
      hold_cnt  <= cnt_nxt;
      last      <= last_nxt;
    end
  end

  // Next-state logic: grant from idle, or release/switch/hold during a tenure.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_nxt   = state;
    idx_nxt     = gnt_idx;
    valid_nxt   = gnt_valid;
    cnt_nxt     = hold_cnt;
    last_nxt    = last;
    preempt_nxt = 1'b0;
    hit         = '0;
    keep        = 1'b0;
    timeout     = 1'b0;

    case (state)
      IDLE: begin
        hit = search(req, last);
        if (hit.found) begin
          idx_nxt   = hit.idx;
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = GRANT;
        end
      end

      GRANT: begin
        keep    = req[gnt_idx];
        timeout = LIMIT_EN && keep && (hold_cnt == HOLD_LAST);
        if (!keep || timeout) begin
          // Release: the holder becomes the new pointer; same-edge requests compete,
          // and a lone timed-out holder wins again because the scan wraps to it.
          last_nxt    = gnt_idx;
          preempt_nxt = timeout;
          cnt_nxt     = '0;
          hit         = search(req, gnt_idx);
          if (hit.found) begin
            idx_nxt = hit.idx;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end else if (hold_cnt != CNT_MAX) begin
          cnt_nxt = hold_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 (MAX_HOLD=8) with hand-computed expectations.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge, then settle 1 time unit past it before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                           input logic ev, input logic ep);
    check({tag, ".gnt"}, gnt, eg);
    if (ev) check({tag, ".idx"}, gnt_idx, ei);
    check({tag, ".valid"}, gnt_valid, ev);
    check({tag, ".preempt"}, preempt, ep);
  endtask

  initial begin
    logic [3:0] eg;
    int         e;

    // Reset values while rst_n is low.
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    check_all("rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("rst.idx", gnt_idx, 2'd0);
    rst_n = 1'b1;

    // Single requester 2, granted one cycle later.
    req = 4'b0100;
    tick();
    check_all("req2", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Hold for 20 cycles total: timeouts re-grant 2 and pulse preempt after cycles 8 and 16.
    for (int c = 2; c <= 20; c++) begin
      tick();
      check_all($sformatf("hold2.c%0d", c), 4'b0100, 2'd2, 1'b1, (c == 9) || (c == 17));
    end

    // All four requesting: 0,1,2,3,0 with 8-cycle tenures and no bubbles.
    do_reset();
    req = 4'b1111;
    for (int t = 1; t <= 40; t++) begin
      tick();
      e  = ((t - 1) / 8) % 4;
      eg = 4'b0001 << e;
      check_all($sformatf("rr.t%0d", t), eg, 2'(e), 1'b1, (t > 1) && ((t - 1) % 8 == 0));
    end

    // Release straight to a waiting requester with no idle bubble.
    do_reset();
    req = 4'b0001;
    tick();
    check_all("sw.g0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b1001;
    tick();
    check_all("sw.nodisturb", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b1000;
    tick();
    check_all("sw.g3", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Grant 1, all drop to idle, then 0011 wraps to requester 0.
    do_reset();
    req = 4'b0010;
    tick();
    check_all("idle.g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    check_all("idle.drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0011;
    tick();
    check_all("idle.wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Async reset mid-tenure; pointer moved to 2 first so a survivor would favour 3.
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    check_all("ar.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0100;
    tick();
    check_all("ar.g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("ar.async", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("ar.async.idx", gnt_idx, 2'd0);
    req = 4'b0000;
    tick();
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    check_all("ar.from0", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
